// File: rtl/iter_display_ctrl.sv
// BCD generation counter with tick/step advance and a multiplexed seven-segment scan.
// Optional LEADING_ZERO_BLANK_EN blanks zero digits above the most significant non-zero digit.
module iter_display_ctrl #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned TICK_DIV    = 100_000_000,
    parameter int unsigned REFRESH_DIV = 100_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  step,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  overflow,
    output logic [DIGITS-1:0]     anode,
    output logic [7:0]            cathode
);

    localparam int unsigned TickW = $clog2(TICK_DIV);
    localparam int unsigned RefW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned SelW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [TickW-1:0]    tick_cnt_q, tick_cnt_d;
    logic [RefW-1:0]     ref_cnt_q, ref_cnt_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic                step_q;
    logic [4*DIGITS-1:0] count_q, count_d, count_inc;
    logic                overflow_q, overflow_d;
    logic [DIGITS-1:0]   anode_q;
    logic [7:0]          cathode_q;

    logic tick_hit, inc_req, all_nine, carry, blank;
    logic [3:0] digit_sel;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick_hit = en && (tick_cnt_q == TickW'(TICK_DIV - 1));
    // Step only counts while paused, but step_q tracks regardless so resuming never fakes an edge.
    assign inc_req  = en ? tick_hit : (step && !step_q);

    always_comb begin
        carry     = 1'b1;
        all_nine  = 1'b1;
        count_inc = count_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (count_q[4*k +: 4] != 4'd9) all_nine = 1'b0;
            if (carry) begin
                if (count_q[4*k +: 4] == 4'd9) begin
                    count_inc[4*k +: 4] = 4'd0;
                end else begin
                    count_inc[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (inc_req) begin
            count_d = count_inc;
            if (all_nine) overflow_d = 1'b1;
        end

        if (!en || clear || tick_hit) tick_cnt_d = '0;
        else                          tick_cnt_d = tick_cnt_q + TickW'(1);

        ref_cnt_d = ref_cnt_q + RefW'(1);
        sel_d     = sel_q;
        if (ref_cnt_q == RefW'(REFRESH_DIV - 1)) begin
            ref_cnt_d = '0;
            sel_d     = (sel_q == SelW'(DIGITS - 1)) ? '0 : sel_q + SelW'(1);
        end
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic upper_zero;
        upper_zero = 1'b1;
`endif
        digit_sel = 4'd0;
        blank     = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            // upper_zero covers digits k..DIGITS-1 at this point in the descending walk
            upper_zero = upper_zero && (count_q[4*k +: 4] == 4'd0);
            if (sel_q == SelW'(k)) blank = (k != 0) && upper_zero;
`endif
            if (sel_q == SelW'(k)) digit_sel = count_q[4*k +: 4];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_cnt_q <= '0;
            ref_cnt_q  <= '0;
            sel_q      <= '0;
            step_q     <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            anode_q    <= '1;
            cathode_q  <= 8'hFF;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            sel_q      <= sel_d;
            step_q     <= step;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            anode_q    <= ~(DIGITS'(1) << sel_q);
            cathode_q  <= blank ? 8'hFF : seg7(digit_sel);
        end
    end

    assign count_bcd = count_q;
    assign overflow  = overflow_q;
    assign anode     = anode_q;
    assign cathode   = cathode_q;

endmodule

// File: tb/tb_iter_display_ctrl.sv
// Scoreboard bench for iter_display_ctrl: a cycle model queues expected outputs per driven cycle.
// Directed checks cover the tick, step, wrap, clear, scan and reset scenarios.
module tb_iter_display_ctrl;

    localparam int D  = 4;
    localparam int TD = 4;
    localparam int RD = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0, en = 1'b0, step = 1'b0, clear = 1'b0;
    logic [4*D-1:0] count_bcd;
    logic          overflow;
    logic [D-1:0]  anode;
    logic [7:0]    cathode;

    iter_display_ctrl #(.DIGITS(D), .TICK_DIV(TD), .REFRESH_DIV(RD)) dut (
        .clk(clk), .reset(reset), .en(en), .step(step), .clear(clear),
        .count_bcd(count_bcd), .overflow(overflow), .anode(anode), .cathode(cathode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cnt;
        logic        ov;
        logic [3:0]  an;
        logic [7:0]  ca;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int   m_cnt = 0, m_tick = 0, m_ref = 0, m_sel = 0;
    bit   m_ov = 0, m_stepq = 0;
    logic [3:0] m_an = 4'hF;
    logic [7:0] m_ca = 8'hFF;
    logic [7:0] scan_tab[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] seg_of(input int d);
        logic [7:0] tab[10];
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return tab[d];
    endfunction

    function automatic logic [7:0] exp_cath(input int slot, input int value);
        int p = 1;
        for (int i = 0; i < slot; i++) p = p * 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot > 0 && value < p) return 8'hFF;
`endif
        return seg_of((value / p) % 10);
    endfunction

    // One clock: drive inputs, advance the model, queue expectation, then compare after the edge.
    task automatic cyc(input bit rst_n, input bit en_v, input bit step_v, input bit clr_v);
        exp_t e;
        bit   inc;
        @(negedge clk);
        reset = rst_n; en = en_v; step = step_v; clear = clr_v;
        if (!rst_n) begin
            m_cnt = 0; m_ov = 0; m_tick = 0; m_ref = 0; m_sel = 0; m_stepq = 0;
            m_an = 4'hF; m_ca = 8'hFF;
        end else begin
            inc     = en_v ? (m_tick == TD - 1) : (step_v && !m_stepq);
            m_stepq = step_v;
            m_an    = ~(4'b1 << m_sel);
            m_ca    = exp_cath(m_sel, m_cnt);
            if (clr_v) begin
                m_cnt = 0; m_ov = 0;
            end else if (inc) begin
                if (m_cnt == 9999) begin m_cnt = 0; m_ov = 1; end
                else m_cnt = m_cnt + 1;
            end
            m_tick = (!en_v || clr_v || m_tick == TD - 1) ? 0 : m_tick + 1;
            if (m_ref == RD - 1) begin m_ref = 0; m_sel = (m_sel + 1) % D; end
            else m_ref = m_ref + 1;
        end
        e.cnt = to_bcd(m_cnt); e.ov = m_ov; e.an = m_an; e.ca = m_ca;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq("sb_count", count_bcd, e.cnt);
        check_eq("sb_overflow", overflow, e.ov);
        check_eq("sb_anode", anode, e.an);
        check_eq("sb_cathode", cathode, e.ca);
    endtask

    task automatic step_to(input int target);
        while (m_cnt != target) begin
            cyc(1, 0, 1, 0);
            cyc(1, 0, 0, 0);
        end
    endtask

    initial begin
`ifdef LEADING_ZERO_BLANK_EN
        scan_tab = '{8'h92, 8'hC0, 8'hB0, 8'hFF};
`else
        scan_tab = '{8'h92, 8'hC0, 8'hB0, 8'hC0};
`endif
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check_eq("rst_anode", anode, 4'hF);
        check_eq("rst_cathode", cathode, 8'hFF);
        check_eq("rst_count", count_bcd, 16'h0);

        // Auto increment every TD edges
        cyc(1, 1, 0, 0);
        check_eq("first_anode", anode, 4'b1110);
        check_eq("first_cathode", cathode, 8'hC0);
        for (int i = 2; i <= 8; i++) begin
            cyc(1, 1, 0, 0);
            if (i == 3) check_eq("auto_before", count_bcd, 16'h0000);
            if (i == 4) check_eq("auto_1", count_bcd, 16'h0001);
            if (i == 8) check_eq("auto_2", count_bcd, 16'h0002);
        end

        // Pause and single-step
        cyc(1, 0, 0, 0);
        step_to(9);
        check_eq("preload_9", count_bcd, 16'h0009);
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0);
        check_eq("step_held", count_bcd, 16'h0010);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        check_eq("step_while_en", count_bcd, 16'h0010);
        cyc(1, 0, 1, 0);
        check_eq("step_held_resume", count_bcd, 16'h0010);
        cyc(1, 0, 0, 0);

        // Wrap and sticky overflow, then clear
        step_to(9999);
        check_eq("pre_wrap", count_bcd, 16'h9999);
        check_eq("pre_wrap_ov", overflow, 1'b0);
        cyc(1, 0, 1, 0);
        check_eq("wrap_count", count_bcd, 16'h0000);
        check_eq("wrap_ov", overflow, 1'b1);
        cyc(1, 0, 0, 0);
        step_to(2);
        check_eq("ov_sticky", overflow, 1'b1);
        cyc(1, 0, 0, 1);
        check_eq("clear_count", count_bcd, 16'h0000);
        check_eq("clear_ov", overflow, 1'b0);

        // Clear wins over a coincident tick increment
        step_to(41);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_eq("pre_clr_tick", count_bcd, 16'h0041);
        cyc(1, 1, 0, 1);
        check_eq("clr_vs_tick", count_bcd, 16'h0000);
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        check_eq("post_clr_wait", count_bcd, 16'h0000);
        cyc(1, 1, 0, 0);
        check_eq("post_clr_tick", count_bcd, 16'h0001);

        // Scan pattern at 0305
        cyc(1, 0, 0, 1);
        step_to(305);
        begin
            logic [3:0] prev_an = 4'hF;
            int run = 0;
            bit first = 1;
            for (int c = 0; c < 4 * D * RD; c++) begin
                cyc(1, 0, 0, 0);
                for (int k = 0; k < D; k++) begin
                    if (anode == ~(4'b1 << k)) check_eq("scan_cathode", cathode, scan_tab[k]);
                end
                if (anode != prev_an) begin
                    if (!first) check_eq("scan_run", run, RD);
                    first   = (prev_an == 4'hF);
                    prev_an = anode;
                    run     = 1;
                end else begin
                    run++;
                end
            end
        end

        // Reset mid-scan with overflow set
        step_to(9999);
        cyc(1, 0, 1, 0);
        cyc(1, 0, 0, 0);
        step_to(123);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        check_eq("pre_rst_count", count_bcd, 16'h0123);
        check_eq("pre_rst_ov", overflow, 1'b1);
        cyc(0, 1, 0, 0);
        check_eq("midrst_anode", anode, 4'hF);
        check_eq("midrst_cathode", cathode, 8'hFF);
        check_eq("midrst_count", count_bcd, 16'h0000);
        check_eq("midrst_ov", overflow, 1'b0);
        cyc(1, 0, 0, 0);
        check_eq("post_rst_anode", anode, 4'b1110);
        check_eq("post_rst_cathode", cathode, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
